// File: rtl/multi_clock_divider.sv
// Multi-channel programmable divider/strobe generator with shadowed per-channel config.
// Shadow configs take effect at period boundaries, on sync_i, or at once when a channel is OFF.
module multi_clock_divider #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int CH_BITS  = 2
) (
  input  logic                clk_i,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_BITS-1:0]  cfg_ch,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [WIDTH-1:0]    cfg_high,
  input  logic [1:0]          cfg_mode,
  input  logic                sync_i,
  output logic [CHANNELS-1:0] clk_o,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] pend_o
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_DUTY  = 2'd1,
    MODE_PULSE = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  logic [WIDTH-1:0] period_c;
  logic [WIDTH-1:0] high_c;

  // Clamp once; every channel's shadow load sees the already-legal values.
  always_comb begin
    period_c = (cfg_period < WIDTH'(2)) ? WIDTH'(2) : cfg_period;
    high_c   = (cfg_high > period_c) ? period_c : cfg_high;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] period_a, high_a, count;
    logic [WIDTH-1:0] period_s, high_s;
    mode_t            mode_a, mode_s;
    logic             pend;
    logic             clk_q, tick_q;
    logic             wr_hit, running, at_end, bypass, apply_shadow;

    always_comb begin
      wr_hit       = cfg_we && (cfg_ch == CH_BITS'(g));
      running      = (mode_a == MODE_DUTY) || (mode_a == MODE_PULSE);
      at_end       = running && (count == period_a - WIDTH'(1));
      // An idle channel takes a write directly unless a sync claims this edge.
      bypass       = wr_hit && !running && !sync_i;
      apply_shadow = pend && (sync_i || !running || at_end);
    end

    always_ff @(posedge clk_i) begin
      if (reset) begin
        period_a <= WIDTH'(2);
        high_a   <= WIDTH'(1);
        mode_a   <= MODE_OFF;
        count    <= '0;
        period_s <= '0;
        high_s   <= '0;
        mode_s   <= MODE_OFF;
        pend     <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        case (mode_a)
          MODE_DUTY: begin
            clk_q  <= (count < high_a);
            tick_q <= (count == '0);
          end
          MODE_PULSE: begin
            clk_q  <= (count == '0);
            tick_q <= (count == '0);
          end
          default: begin
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
          end
        endcase

        if (sync_i || !running || at_end) count <= '0;
        else                              count <= count + WIDTH'(1);

        if (bypass) begin
          period_a <= period_c;
          high_a   <= high_c;
          mode_a   <= mode_t'(cfg_mode);
          pend     <= 1'b0;
        end else if (apply_shadow) begin
          period_a <= period_s;
          high_a   <= high_s;
          mode_a   <= mode_s;
          pend     <= 1'b0;
        end

        // A write coinciding with an apply edge stays pending for the next one.
        if (wr_hit && !bypass) begin
          period_s <= period_c;
          high_s   <= high_c;
          mode_s   <= mode_t'(cfg_mode);
          pend     <= 1'b1;
        end
      end
    end

    assign clk_o[g]  = clk_q;
    assign tick_o[g] = tick_q;
    assign pend_o[g] = pend;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider; a 3-channel copy covers out-of-range channel writes.
module tb_multi_clock_divider;
  logic        clk_i = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_high = '0;
  logic [1:0]  cfg_mode = '0;
  logic        sync_i = 1'b0;
  logic [3:0]  clk_o, tick_o, pend_o;
  logic [2:0]  clk3_o, tick3_o, pend3_o;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  multi_clock_divider #(.CHANNELS(4), .WIDTH(16), .CH_BITS(2)) dut (
    .clk_i(clk_i), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_mode(cfg_mode),
    .sync_i(sync_i), .clk_o(clk_o), .tick_o(tick_o), .pend_o(pend_o)
  );

  multi_clock_divider #(.CHANNELS(3), .WIDTH(16), .CH_BITS(2)) dut3 (
    .clk_i(clk_i), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_mode(cfg_mode),
    .sync_i(sync_i), .clk_o(clk3_o), .tick_o(tick3_o), .pend_o(pend3_o)
  );

  task automatic do_reset();
    reset = 1'b1; cfg_we = 1'b0; sync_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset = 1'b0;
  endtask

  task automatic write_cfg(input int ch, input int per, input int hi, input int md);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = 16'(per); cfg_high = 16'(hi); cfg_mode = 2'(md);
    @(negedge clk_i);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({clk_o, tick_o, pend_o} !== 12'h0 || {clk3_o, tick3_o, pend3_o} !== 9'h0) begin
        $display("FAIL reset_outputs cyc%0d got clk=%b tick=%b pend=%b small=%b%b%b exp all 0",
                 i, clk_o, tick_o, pend_o, clk3_o, tick3_o, pend3_o);
        errors++;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_duty();
    write_cfg(0, 4, 1, 1);
    checks++;
    if (clk_o[0] !== 1'b0 || pend_o[0] !== 1'b0) begin
      $display("FAIL duty_apply_edge got clk=%b pend=%b exp 0 0", clk_o[0], pend_o[0]);
      errors++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      checks++;
      if (clk_o[0] !== (i % 4 == 0) || tick_o[0] !== (i % 4 == 0) || pend_o[0] !== 1'b0) begin
        $display("FAIL duty_wave cyc%0d got clk=%b tick=%b pend=%b exp clk=tick=%0d pend=0",
                 i, clk_o[0], tick_o[0], pend_o[0], (i % 4 == 0));
        errors++;
      end
    end
  endtask

  task automatic test_reconfig();
    bit ec[14];
    bit et[14];
    ec = '{1,1,0,0,0,0,0,1,1,0,0,0,0,1};
    et = '{0,0,0,0,0,0,0,1,0,0,0,0,0,1};
    write_cfg(1, 10, 5, 1);
    repeat (3) @(negedge clk_i);
    write_cfg(1, 6, 2, 1);
    for (int j = 0; j < 14; j++) begin
      checks++;
      if (clk_o[1] !== ec[j] || tick_o[1] !== et[j] || pend_o[1] !== (j < 6)) begin
        $display("FAIL reconfig cyc%0d got clk=%b tick=%b pend=%b exp clk=%b tick=%b pend=%0d",
                 j, clk_o[1], tick_o[1], pend_o[1], ec[j], et[j], (j < 6));
        errors++;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_sync();
    bit c0[8], t0[8], p0[8], c2[8], t2[8];
    c0 = '{1,1,0,0,0,1,0,0};
    t0 = '{1,0,0,0,0,1,0,0};
    p0 = '{1,1,1,1,0,0,0,0};
    c2 = '{1,1,1,0,0,0,0,1};
    t2 = '{1,0,0,0,0,0,0,1};
    do_reset();
    write_cfg(0, 5, 2, 1);
    repeat (2) @(negedge clk_i);
    write_cfg(2, 7, 3, 1);
    repeat (5) @(negedge clk_i);
    sync_i = 1'b1;
    write_cfg(0, 8, 1, 1);
    sync_i = 1'b0;
    checks++;
    if (pend_o[0] !== 1'b1) begin
      $display("FAIL sync_write_pend got %b exp 1", pend_o[0]);
      errors++;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      checks++;
      if (clk_o[0] !== c0[k] || tick_o[0] !== t0[k] || pend_o[0] !== p0[k] ||
          clk_o[2] !== c2[k] || tick_o[2] !== t2[k]) begin
        $display("FAIL sync_align cyc%0d got c0=%b t0=%b p0=%b c2=%b t2=%b exp %b %b %b %b %b",
                 k, clk_o[0], tick_o[0], pend_o[0], clk_o[2], tick_o[2], c0[k], t0[k], p0[k], c2[k], t2[k]);
        errors++;
      end
    end
  endtask

  task automatic test_clamp();
    do_reset();
    write_cfg(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      checks++;
      if (clk_o[0] !== 1'b0 || tick_o[0] !== (i % 2 == 0)) begin
        $display("FAIL clamp_period cyc%0d got clk=%b tick=%b exp clk=0 tick=%0d",
                 i, clk_o[0], tick_o[0], (i % 2 == 0));
        errors++;
      end
    end
    write_cfg(1, 3, 9, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      checks++;
      if (clk_o[1] !== 1'b1 || tick_o[1] !== (i % 3 == 0)) begin
        $display("FAIL clamp_high cyc%0d got clk=%b tick=%b exp clk=1 tick=%0d",
                 i, clk_o[1], tick_o[1], (i % 3 == 0));
        errors++;
      end
    end
    write_cfg(3, 4, 2, 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pend3_o !== 3'b000 || clk3_o[2] !== 1'b0 || tick3_o[2] !== 1'b0 || clk3_o[1] !== 1'b1) begin
        $display("FAIL out_of_range_ch cyc%0d got pend=%b clk=%b tick2=%b exp pend=000 clk[2]=0 clk[1]=1",
                 i, pend3_o, clk3_o, tick3_o[2]);
        errors++;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_pulse_off();
    bit ec[5], ep[5];
    ec = '{1,0,0,0,0};
    ep = '{1,1,0,0,0};
    do_reset();
    write_cfg(3, 3, 0, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      checks++;
      if (clk_o[3] !== (i % 3 == 0) || tick_o[3] !== (i % 3 == 0)) begin
        $display("FAIL pulse_wave cyc%0d got clk=%b tick=%b exp both %0d",
                 i, clk_o[3], tick_o[3], (i % 3 == 0));
        errors++;
      end
    end
    write_cfg(3, 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (clk_o[3] !== ec[i] || tick_o[3] !== ec[i] || pend_o[3] !== ep[i]) begin
        $display("FAIL pulse_to_off cyc%0d got clk=%b tick=%b pend=%b exp clk=tick=%b pend=%b",
                 i, clk_o[3], tick_o[3], pend_o[3], ec[i], ep[i]);
        errors++;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 4; c++) write_cfg(c, 4, 4, 1);
    write_cfg(0, 8, 4, 1);
    checks++;
    if (clk_o !== 4'hF || pend_o !== 4'b0001) begin
      $display("FAIL pre_reset_state got clk=%b pend=%b exp 1111 0001", clk_o, pend_o);
      errors++;
    end
    reset = 1'b1;
    @(negedge clk_i);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (clk_o !== 4'h0 || tick_o !== 4'h0 || pend_o !== 4'h0) begin
        $display("FAIL reset_mid cyc%0d got clk=%b tick=%b pend=%b exp all 0",
                 i, clk_o, tick_o, pend_o);
        errors++;
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_reconfig();
    test_sync();
    test_clamp();
    test_pulse_off();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
